pc_unit: RTL and testbench



---
 rtl/pc_unit.sv | 125 ++++++++++++
 tb/tb_pc_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the RISC-V fetch stage.
// Selects the next PC from trap vector, jump target, branch target or
// sequential increment; supports stall, halt/resume and a fetch handshake.
// Optional accepted-fetch counter is built only when PC_FETCH_COUNT_EN is
// defined; otherwise fetch_count is tied to zero.
module pc_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned      INC          = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            fetch_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            pc_valid,
  output logic            misaligned,
  output logic [63:0]     fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Low log2(INC) bits of a redirect target must be zero.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;

  assign pc_out      = pc_q;
  assign pc_plus_inc = pc_q + XLEN'(INC);
  assign pc_valid    = (state_q == ST_RUN);
  assign misaligned  = mis_q;

  // Next-state, next-PC and misalignment flag selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trap) begin
          pc_d = TRAP_VECTOR;
        end else if (pc_write && jump) begin
          if ((jump_target & ALIGN_MASK) != '0) begin
            pc_d  = TRAP_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d = jump_target;
          end
        end else if (pc_write && branch_taken) begin
          if ((branch_target & ALIGN_MASK) != '0) begin
            pc_d  = TRAP_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d = branch_target;
          end
        end else if (pc_write && fetch_ready) begin
          pc_d = pc_plus_inc;
        end
        if (halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (trap) begin
          pc_d    = TRAP_VECTOR;
          state_d = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, PC and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

`ifdef PC_FETCH_COUNT_EN
  logic [63:0] cnt_q;

  // Count every cycle in which a valid PC is accepted by instruction memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (pc_valid && fetch_ready) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: table-driven scenarios, expected values
// pushed to a scoreboard queue on drive and popped after the clock edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, pc_write, fetch_ready, branch_taken, jump, trap;
  logic        halt_req, resume;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_out, pc_plus_inc;
  logic        pc_valid, misaligned;
  logic [63:0] fetch_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        rst, pw, fr, tr, j;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        h, rs;
    logic [31:0] pc;
    logic        v, m;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    logic        v, m;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR(32'h0000_0100),
    .INC(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc_write(pc_write),
    .fetch_ready(fetch_ready),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .trap(trap),
    .halt_req(halt_req),
    .resume(resume),
    .pc_out(pc_out),
    .pc_plus_inc(pc_plus_inc),
    .pc_valid(pc_valid),
    .misaligned(misaligned),
    .fetch_count(fetch_count)
  );

  task automatic apply(input row_t r);
    reset         = r.rst;
    pc_write      = r.pw;
    fetch_ready   = r.fr;
    trap          = r.tr;
    jump          = r.j;
    jump_target   = r.jt;
    branch_taken  = r.br;
    branch_target = r.bt;
    halt_req      = r.h;
    resume        = r.rs;
  endtask

  task automatic test_reset();
    row_t t[6] = '{
      '{0,1,1,0,0,32'h0,0,32'h0,0,0, 32'h0,0,0},
      '{0,1,1,0,0,32'h0,0,32'h0,0,0, 32'h0,0,0},
      '{0,1,1,0,0,32'h0,0,32'h0,0,0, 32'h0,0,0},
      '{1,1,1,0,0,32'h0,0,32'h0,0,0, 32'h0,1,0},
      '{1,1,1,0,0,32'h0,0,32'h0,0,0, 32'h4,1,0},
      '{1,1,1,0,0,32'h0,0,32'h0,0,0, 32'h8,1,0}
    };
    for (int i = 0; i < 6; i++) begin
      apply(t[i]);
      exp_q.push_back('{t[i].pc, t[i].v, t[i].m});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || misaligned !== e.m ||
          pc_plus_inc !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL reset[%0d]: got pc=%h ppi=%h v=%b m=%b, want pc=%h v=%b m=%b",
                 i, pc_out, pc_plus_inc, pc_valid, misaligned, e.pc, e.v, e.m);
      end
    end
  endtask

  task automatic test_stall();
    row_t t[5] = '{
      '{1,1,1,0,1,32'h10,0,32'h0,0,0, 32'h10,1,0},
      '{1,0,1,0,0,32'h0, 0,32'h0,0,0, 32'h10,1,0},
      '{1,0,1,0,0,32'h0, 0,32'h0,0,0, 32'h10,1,0},
      '{1,1,0,0,0,32'h0, 0,32'h0,0,0, 32'h10,1,0},
      '{1,1,1,0,0,32'h0, 0,32'h0,0,0, 32'h14,1,0}
    };
    for (int i = 0; i < 5; i++) begin
      apply(t[i]);
      exp_q.push_back('{t[i].pc, t[i].v, t[i].m});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || misaligned !== e.m ||
          pc_plus_inc !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL stall[%0d]: got pc=%h ppi=%h v=%b m=%b, want pc=%h v=%b m=%b",
                 i, pc_out, pc_plus_inc, pc_valid, misaligned, e.pc, e.v, e.m);
      end
    end
  endtask

  task automatic test_priority();
    row_t t[6] = '{
      '{1,1,1,0,1,32'h20, 0,32'h0, 0,0, 32'h20, 1,0},
      '{1,1,1,1,1,32'h80, 1,32'h40,0,0, 32'h100,1,0},
      '{1,1,1,0,1,32'h80, 1,32'h40,0,0, 32'h80, 1,0},
      '{1,1,1,0,0,32'h0,  1,32'h40,0,0, 32'h40, 1,0},
      '{1,0,0,1,0,32'h0,  0,32'h0, 0,0, 32'h100,1,0},
      '{1,0,1,0,1,32'h200,1,32'h300,0,0,32'h100,1,0}
    };
    for (int i = 0; i < 6; i++) begin
      apply(t[i]);
      exp_q.push_back('{t[i].pc, t[i].v, t[i].m});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || misaligned !== e.m ||
          pc_plus_inc !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL priority[%0d]: got pc=%h ppi=%h v=%b m=%b, want pc=%h v=%b m=%b",
                 i, pc_out, pc_plus_inc, pc_valid, misaligned, e.pc, e.v, e.m);
      end
    end
  endtask

  task automatic test_misaligned();
    row_t t[5] = '{
      '{1,1,1,0,0,32'h0, 1,32'h42,0,0, 32'h100,1,1},
      '{1,1,1,0,0,32'h0, 0,32'h0, 0,0, 32'h104,1,0},
      '{1,1,1,0,1,32'h81,0,32'h0, 0,0, 32'h100,1,1},
      '{1,1,1,1,1,32'h82,0,32'h0, 0,0, 32'h100,1,0},
      '{1,1,1,0,1,32'h84,1,32'h41,0,0, 32'h84, 1,0}
    };
    for (int i = 0; i < 5; i++) begin
      apply(t[i]);
      exp_q.push_back('{t[i].pc, t[i].v, t[i].m});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || misaligned !== e.m ||
          pc_plus_inc !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL misaligned[%0d]: got pc=%h ppi=%h v=%b m=%b, want pc=%h v=%b m=%b",
                 i, pc_out, pc_plus_inc, pc_valid, misaligned, e.pc, e.v, e.m);
      end
    end
  endtask

  task automatic test_wrap_halt();
    row_t t[13] = '{
      '{1,1,1,0,1,32'hFFFF_FFFC,0,32'h0,0,0, 32'hFFFF_FFFC,1,0},
      '{1,1,1,0,0,32'h0, 0,32'h0, 0,0, 32'h0,  1,0},
      '{1,1,1,0,0,32'h0, 0,32'h0, 1,0, 32'h4,  0,0},
      '{1,1,1,0,1,32'h40,1,32'h50,0,0, 32'h4,  0,0},
      '{1,1,1,0,0,32'h0, 0,32'h0, 1,1, 32'h4,  1,0},
      '{1,1,1,0,0,32'h0, 0,32'h0, 0,0, 32'h8,  1,0},
      '{1,1,1,0,0,32'h0, 0,32'h0, 1,0, 32'hC,  0,0},
      '{1,1,1,1,0,32'h0, 0,32'h0, 0,0, 32'h100,1,0},
      '{1,1,1,0,0,32'h0, 0,32'h0, 0,1, 32'h104,1,0},
      '{1,1,1,0,0,32'h0, 0,32'h0, 1,0, 32'h108,0,0},
      '{0,1,1,1,0,32'h0, 0,32'h0, 0,1, 32'h0,  0,0},
      '{1,1,1,0,1,32'h40,0,32'h0, 0,1, 32'h0,  1,0},
      '{1,1,1,0,0,32'h0, 0,32'h0, 0,0, 32'h4,  1,0}
    };
    for (int i = 0; i < 13; i++) begin
      apply(t[i]);
      exp_q.push_back('{t[i].pc, t[i].v, t[i].m});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || misaligned !== e.m ||
          pc_plus_inc !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL wrap_halt[%0d]: got pc=%h ppi=%h v=%b m=%b, want pc=%h v=%b m=%b",
                 i, pc_out, pc_plus_inc, pc_valid, misaligned, e.pc, e.v, e.m);
      end
    end
  endtask

  task automatic test_counter();
    logic        fr_pat[7] = '{1, 0, 1, 1, 0, 1, 1};
    logic [31:0] exp_pc    = 32'h0;
    logic [63:0] exp_cnt   = 64'd0;
    row_t        r         = '{0,1,1,0,0,32'h0,0,32'h0,0,0, 32'h0,0,0};
    // reset, then BOOT cycle: no fetches are counted while pc_valid is low
    for (int i = 0; i < 2; i++) begin
      r.rst = (i == 1);
      apply(r);
      exp_q.push_back('{32'h0, i == 1, 1'b0});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || fetch_count !== 64'd0) begin
        errors++;
        $display("FAIL counter_boot[%0d]: got pc=%h v=%b cnt=%0d, want pc=%h v=%b cnt=0",
                 i, pc_out, pc_valid, fetch_count, e.pc, e.v);
      end
    end
    for (int i = 0; i < 7; i++) begin
      r.rst = 1'b1;
      r.fr  = fr_pat[i];
      apply(r);
      if (fr_pat[i]) begin
        exp_pc = exp_pc + 32'd4;
`ifdef PC_FETCH_COUNT_EN
        exp_cnt = exp_cnt + 64'd1;
`endif
      end
      exp_q.push_back('{exp_pc, 1'b1, 1'b0});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || fetch_count !== exp_cnt) begin
        errors++;
        $display("FAIL counter_run[%0d]: got pc=%h v=%b cnt=%0d, want pc=%h v=%b cnt=%0d",
                 i, pc_out, pc_valid, fetch_count, e.pc, e.v, exp_cnt);
      end
    end
    r.rst = 1'b0;
    apply(r);
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== e.pc || pc_valid !== e.v || fetch_count !== 64'd0) begin
      errors++;
      $display("FAIL counter_reset: got pc=%h v=%b cnt=%0d, want pc=%h v=%b cnt=0",
               pc_out, pc_valid, fetch_count, e.pc, e.v);
    end
  endtask

  initial begin
    apply('{0,0,0,0,0,32'h0,0,32'h0,0,0, 32'h0,0,0});
    test_reset();
    test_stall();
    test_priority();
    test_misaligned();
    test_wrap_halt();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
